mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage between the E/M pipeline register and the W pipeline register.
- Decodes load/store from M-stage fields and runs a req/ack transaction on the data-memory port.
- Aligns and extends load data into m_valM for the W register.
- Holds the pipeline via a stall request to the hazard unit until the access completes.

Parameters:
XLEN, 64, datapath width; equals `CPU_WIDTH
STRB_W, XLEN/8, byte-strobe width
ADDR_LSB, 3, number of byte-offset bits (log2 STRB_W)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
M_opcode_i  in  7  M-stage opcode; 7'h03 load, 7'h23 store, anything else is a non-memory op
M_funct3_i  in  3  access size/sign
M_valE_i  in  XLEN  effective address
M_valA_i  in  XLEN  store data
M_stall_i  in  1  M stage frozen by hazard unit (downstream hold)
dmem_req_o  out  1  request valid
dmem_we_o  out  1  1 = store
dmem_addr_o  out  XLEN  address, low ADDR_LSB bits forced to 0
dmem_wdata_o  out  XLEN  lane-aligned store data
dmem_wstrb_o  out  STRB_W  byte strobes, 0 for loads
dmem_ack_i  in  1  request accepted/completed; dmem_rdata_i valid this cycle for loads
dmem_rdata_i  in  XLEN  aligned read word
m_valM_o  out  XLEN  load result to the W register
mem_stall_o  out  1  stall request to the hazard unit
mem_err_o  out  1  misaligned access flag (feature only, else tied 0)

Behaviour:
- Memory op: mem_op = (opcode==7'h03) | (opcode==7'h23).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - dmem_req_o = mem_op, combinational.
  - mem_op & ack → DONE.
  - mem_op & !ack → BUSY.
- BUSY:
  - dmem_req_o = 1; address, data and strobes held from M inputs, which are stable because the stage is stalled.
  - ack → DONE.
- DONE:
  - dmem_req_o = 0.
  - !M_stall_i → IDLE; M_stall_i → stay in DONE. No re-issue while held.
- mem_stall_o = (IDLE & mem_op) | BUSY. It is low in DONE and for non-memory ops.
- Minimum latency: a memory op spends 2 cycles in M (issue+ack, then DONE). Each extra wait cycle on ack adds 1.
- Load data:
  - On an ack cycle of a load, capture into rdata_q the value rdata >> (addr[2:0]*8), then extend per funct3.
  - funct3 0 LB sign-extends 8 bits; 1 LH sign-extends 16; 2 LW sign-extends 32; 3 LD takes full 64.
  - funct3 4 LBU, 5 LHU, 6 LWU zero-extend 8/16/32.
  - funct3 7 gives 0.
- Store lanes:
  - size = funct3[1:0] (0 byte, 1 half, 2 word, 3 dword).
  - wdata = valA[size bytes] replicated across the bus.
  - wstrb = ((1<<(1<<size))-1) << addr[2:0], truncated to STRB_W.
- m_valM_o = rdata_q while in DONE with a load, else 0.
- rdata_q persists until the next load ack.
- Reset, including assertion mid-transaction:
  - State → IDLE; rdata_q → 0.
  - All outputs 0: req 0, we 0, addr 0, wdata 0, wstrb 0, m_valM 0, mem_stall 0, mem_err 0.
  - An in-flight request is abandoned; late acks after reset are ignored unless IDLE sees a new mem_op.
- Ack in IDLE with no mem_op: ignored.
- Ack in DONE: ignored.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- With it defined:
  - An access is misaligned when addr[2:0] & ((1<<size)-1) != 0.
  - A misaligned op issues no request; FSM goes IDLE → DONE directly.
  - mem_err_o = 1 for the whole DONE residency; m_valM_o = 0.
- Without it:
  - No check; mem_err_o tied 0.
  - Misaligned accesses are issued, and strobes are truncated to the bus width.

Test Plan:
- LB, addr 0x1003, rdata 0x0000_0000_8000_0000, ack same cycle → stall=1 for 1 cycle, then DONE with m_valM=0xFFFF_FFFF_FFFF_FF80.
- SH, addr 0x2002, valA 0x1234_ABCD, ack after 3 wait cycles → req held 4 cycles, wstrb=0x0C, wdata lanes[3:2]=0xABCD, we=1, stall 4 cycles.
- LWU, addr 0x4, rdata 0xDEAD_BEEF_0000_0000, M_stall_i=1 for 2 cycles in DONE → m_valM=0xDEAD_BEEF held 3 cycles, no second req.
- Reset asserted while in BUSY (ack pending) → all outputs 0 immediately; ack arriving afterwards with opcode=0x13 → no state change.
- Non-memory opcode 0x33 with ack=1 → req=0, stall=0, m_valM=0.
- MEM_MISALIGN_CHECK_EN: LD, addr 0x1004 → no req, mem_err=1 next cycle, stall=1 for exactly 1 cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory transaction, load align/extend, store lane placement.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

// state | meaning
// IDLE  | no access in flight; request driven combinationally for a memory op
// BUSY  | request issued, waiting for dmem_ack_i
// DONE  | access finished; load result / error presented until the M stage advances
module mem_stage #(
  parameter int XLEN     = `CPU_WIDTH,
  parameter int STRB_W   = XLEN / 8,
  parameter int ADDR_LSB = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [6:0]        M_opcode_i,
  input  logic [2:0]        M_funct3_i,
  input  logic [XLEN-1:0]   M_valE_i,
  input  logic [XLEN-1:0]   M_valA_i,
  input  logic              M_stall_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [STRB_W-1:0] dmem_wstrb_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [XLEN-1:0]   m_valM_o,
  output logic              mem_stall_o,
  output logic              mem_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic            ld_q;
  logic            err_q;
  logic [XLEN-1:0] rdata_q;

  logic                is_load;
  logic                is_store;
  logic                mem_op;
  logic                misaligned;
  logic                issue;
  logic [1:0]          size;
  logic [ADDR_LSB-1:0] off;
  logic [XLEN-1:0]     rd_shift;
  logic [XLEN-1:0]     ld_ext;
  logic [XLEN-1:0]     wdata_c;
  logic [STRB_W-1:0]   strb_mask;
  logic [STRB_W-1:0]   wstrb_c;

  assign is_load  = (M_opcode_i == 7'h03);
  assign is_store = (M_opcode_i == 7'h23);
  assign mem_op   = is_load | is_store;
  assign size     = M_funct3_i[1:0];
  assign off      = M_valE_i[ADDR_LSB-1:0];
  assign rd_shift = dmem_rdata_i >> {off, 3'b000};

  always_comb begin
    ld_ext = '0;
    case (M_funct3_i)
      3'd0:    ld_ext = {{(XLEN-8){rd_shift[7]}},   rd_shift[7:0]};
      3'd1:    ld_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'd2:    ld_ext = {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
      3'd3:    ld_ext = rd_shift;
      3'd4:    ld_ext = {{(XLEN-8){1'b0}},  rd_shift[7:0]};
      3'd5:    ld_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      3'd6:    ld_ext = {{(XLEN-32){1'b0}}, rd_shift[31:0]};
      default: ld_ext = '0;
    endcase
  end

  // Store data is replicated across every lane so the strobes alone pick the bytes.
  always_comb begin
    wdata_c   = M_valA_i;
    strb_mask = STRB_W'(8'hFF);
    case (size)
      2'd0: begin
        wdata_c   = {(XLEN/8){M_valA_i[7:0]}};
        strb_mask = STRB_W'(8'h01);
      end
      2'd1: begin
        wdata_c   = {(XLEN/16){M_valA_i[15:0]}};
        strb_mask = STRB_W'(8'h03);
      end
      2'd2: begin
        wdata_c   = {(XLEN/32){M_valA_i[31:0]}};
        strb_mask = STRB_W'(8'h0F);
      end
      default: begin
        wdata_c   = M_valA_i;
        strb_mask = STRB_W'(8'hFF);
      end
    endcase
  end

  // Strobes that run past the top lane are dropped by the shift width.
  assign wstrb_c = strb_mask << off;

`ifdef MEM_MISALIGN_CHECK_EN
  logic [ADDR_LSB-1:0] align_mask;
  always_comb begin
    case (size)
      2'd0:    align_mask = '0;
      2'd1:    align_mask = ADDR_LSB'(1);
      2'd2:    align_mask = ADDR_LSB'(3);
      default: align_mask = ADDR_LSB'(7);
    endcase
  end
  assign misaligned = mem_op && ((off & align_mask) != '0);
`else
  assign misaligned = 1'b0;
`endif

  // Reset gates the combinational outputs so an in-flight request drops immediately.
  assign issue        = rst_n_i && (((state == IDLE) && mem_op && !misaligned) || (state == BUSY));
  assign dmem_req_o   = issue;
  assign dmem_we_o    = issue && is_store;
  assign dmem_addr_o  = issue ? {M_valE_i[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}} : '0;
  assign dmem_wdata_o = (issue && is_store) ? wdata_c : '0;
  assign dmem_wstrb_o = (issue && is_store) ? wstrb_c : '0;
  assign mem_stall_o  = rst_n_i && (((state == IDLE) && mem_op) || (state == BUSY));
  assign m_valM_o     = ((state == DONE) && ld_q) ? rdata_q : '0;
  assign mem_err_o    = (state == DONE) && err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      rdata_q <= '0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            if (misaligned) begin
              state <= DONE;
              ld_q  <= 1'b0;
              err_q <= 1'b1;
            end else if (dmem_ack_i) begin
              state <= DONE;
              ld_q  <= is_load;
              err_q <= 1'b0;
              if (is_load) rdata_q <= ld_ext;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack_i) begin
            state <= DONE;
            ld_q  <= is_load;
            err_q <= 1'b0;
            if (is_load) rdata_q <= ld_ext;
          end
        end
        DONE: begin
          if (!M_stall_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores, wait states, holds, reset abort.
module tb_mem_stage;
  localparam int XLEN   = 64;
  localparam int STRB_W = XLEN / 8;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [6:0]        M_opcode_i;
  logic [2:0]        M_funct3_i;
  logic [XLEN-1:0]   M_valE_i;
  logic [XLEN-1:0]   M_valA_i;
  logic              M_stall_i;
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic [XLEN-1:0]   dmem_addr_o;
  logic [XLEN-1:0]   dmem_wdata_o;
  logic [STRB_W-1:0] dmem_wstrb_o;
  logic              dmem_ack_i;
  logic [XLEN-1:0]   dmem_rdata_i;
  logic [XLEN-1:0]   m_valM_o;
  logic              mem_stall_o;
  logic              mem_err_o;

  int checks   = 0;
  int failures = 0;

  mem_stage dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .M_opcode_i   (M_opcode_i),
    .M_funct3_i   (M_funct3_i),
    .M_valE_i     (M_valE_i),
    .M_valA_i     (M_valA_i),
    .M_stall_i    (M_stall_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_wstrb_o (dmem_wstrb_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .m_valM_o     (m_valM_o),
    .mem_stall_o  (mem_stall_o),
    .mem_err_o    (mem_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] vala, input logic [63:0] rdata, input logic ack);
    M_opcode_i   = op;
    M_funct3_i   = f3;
    M_valE_i     = addr;
    M_valA_i     = vala;
    dmem_rdata_i = rdata;
    dmem_ack_i   = ack;
  endtask

  // Load acked in its issue cycle, then one DONE cycle, then back to a nop.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] rdata, input logic [63:0] exp);
    set_op(7'h03, f3, addr, 64'h0, rdata, 1'b1);
    settle();
    chk({tag, "_req"},   64'(dmem_req_o), 64'd1);
    chk({tag, "_addr"},  dmem_addr_o, {addr[63:3], 3'b000});
    chk({tag, "_wstrb"}, 64'(dmem_wstrb_o), 64'h0);
    tick();
    dmem_ack_i = 1'b0;
    settle();
    chk({tag, "_valM"},  m_valM_o, exp);
    chk({tag, "_stall"}, 64'(mem_stall_o), 64'd0);
    tick();
    M_opcode_i = 7'h13;
    tick();
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] vala, input logic [63:0] exp_wdata,
                           input logic [7:0] exp_wstrb);
    set_op(7'h23, f3, addr, vala, 64'h0, 1'b1);
    settle();
    chk({tag, "_we"},    64'(dmem_we_o), 64'd1);
    chk({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
    chk({tag, "_wstrb"}, 64'(dmem_wstrb_o), 64'(exp_wstrb));
    tick();
    dmem_ack_i = 1'b0;
    settle();
    chk({tag, "_done_req"}, 64'(dmem_req_o), 64'd0);
    chk({tag, "_done_valM"}, m_valM_o, 64'h0);
    tick();
    M_opcode_i = 7'h13;
    tick();
  endtask

  initial begin
    rst_n_i   = 1'b0;
    M_stall_i = 1'b0;
    set_op(7'h03, 3'd3, 64'h1008, 64'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    #3;
    chk("rst_req",   64'(dmem_req_o), 64'd0);
    chk("rst_we",    64'(dmem_we_o), 64'd0);
    chk("rst_addr",  dmem_addr_o, 64'h0);
    chk("rst_wdata", dmem_wdata_o, 64'h0);
    chk("rst_wstrb", 64'(dmem_wstrb_o), 64'h0);
    chk("rst_valM",  m_valM_o, 64'h0);
    chk("rst_stall", 64'(mem_stall_o), 64'd0);
    chk("rst_err",   64'(mem_err_o), 64'd0);
    tick();
    set_op(7'h13, 3'd0, 64'h0, 64'h0, 64'h0, 1'b0);
    rst_n_i = 1'b1;
    tick();

    // LB at 0x1003, acked immediately
    set_op(7'h03, 3'd0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b1);
    settle();
    chk("lb_req",   64'(dmem_req_o), 64'd1);
    chk("lb_we",    64'(dmem_we_o), 64'd0);
    chk("lb_addr",  dmem_addr_o, 64'h1000);
    chk("lb_stall", 64'(mem_stall_o), 64'd1);
    tick();
    dmem_ack_i = 1'b0;
    settle();
    chk("lb_done_stall", 64'(mem_stall_o), 64'd0);
    chk("lb_done_req",   64'(dmem_req_o), 64'd0);
    chk("lb_valM",       m_valM_o, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    M_opcode_i = 7'h13;
    settle();
    chk("lb_idle_valM", m_valM_o, 64'h0);
    tick();

    // SH at 0x2002 with three wait cycles before ack
    set_op(7'h23, 3'd1, 64'h2002, 64'h1234_ABCD, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("sh_wait%0d_req", i),   64'(dmem_req_o), 64'd1);
      chk($sformatf("sh_wait%0d_stall", i), 64'(mem_stall_o), 64'd1);
      chk($sformatf("sh_wait%0d_wstrb", i), 64'(dmem_wstrb_o), 64'h0C);
      tick();
    end
    dmem_ack_i = 1'b1;
    settle();
    chk("sh_ack_req",   64'(dmem_req_o), 64'd1);
    chk("sh_ack_stall", 64'(mem_stall_o), 64'd1);
    chk("sh_we",        64'(dmem_we_o), 64'd1);
    chk("sh_addr",      dmem_addr_o, 64'h2000);
    chk("sh_wdata",     dmem_wdata_o, 64'hABCD_ABCD_ABCD_ABCD);
    tick();
    dmem_ack_i = 1'b0;
    settle();
    chk("sh_done_req",   64'(dmem_req_o), 64'd0);
    chk("sh_done_stall", 64'(mem_stall_o), 64'd0);
    chk("sh_done_valM",  m_valM_o, 64'h0);
    tick();
    M_opcode_i = 7'h13;
    tick();

    // LWU at 0x4 held in DONE by the hazard unit for two extra cycles
    set_op(7'h03, 3'd6, 64'h4, 64'h0, 64'hDEAD_BEEF_0000_0000, 1'b1);
    settle();
    chk("lwu_stall", 64'(mem_stall_o), 64'd1);
    tick();
    dmem_ack_i = 1'b0;
    M_stall_i  = 1'b1;
    settle();
    chk("lwu_hold0_valM", m_valM_o, 64'hDEAD_BEEF);
    chk("lwu_hold0_req",  64'(dmem_req_o), 64'd0);
    tick();
    dmem_ack_i = 1'b1;
    settle();
    chk("lwu_hold1_valM",  m_valM_o, 64'hDEAD_BEEF);
    chk("lwu_hold1_req",   64'(dmem_req_o), 64'd0);
    chk("lwu_hold1_stall", 64'(mem_stall_o), 64'd0);
    tick();
    dmem_ack_i = 1'b0;
    M_stall_i  = 1'b0;
    settle();
    chk("lwu_hold2_valM", m_valM_o, 64'hDEAD_BEEF);
    chk("lwu_hold2_req",  64'(dmem_req_o), 64'd0);
    tick();
    M_opcode_i = 7'h13;
    settle();
    chk("lwu_release_valM", m_valM_o, 64'h0);
    tick();

    // Load size/sign variants
    run_load("lh",   3'd1, 64'h6,  64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    run_load("lw",   3'd2, 64'h0,  64'h0000_0000_8765_4321, 64'hFFFF_FFFF_8765_4321);
    run_load("ld",   3'd3, 64'h8,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    run_load("lbu",  3'd4, 64'h1,  64'h0000_0000_0000_F000, 64'h0000_0000_0000_00F0);
    run_load("lhu",  3'd5, 64'h2,  64'h0000_0000_9999_0000, 64'h0000_0000_0000_9999);
    run_load("f3_7", 3'd7, 64'h0,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0);

    // Store lane variants
    run_store("sb", 3'd0, 64'h5, 64'hAB,                  64'hABAB_ABAB_ABAB_ABAB, 8'h20);
    run_store("sw", 3'd2, 64'h4, 64'h1122_3344,           64'h1122_3344_1122_3344, 8'hF0);
    run_store("sd", 3'd3, 64'h0, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 8'hFF);

`ifdef MEM_MISALIGN_CHECK_EN
    set_op(7'h03, 3'd3, 64'h1004, 64'h0, 64'h0, 1'b0);
    settle();
    chk("mis_req",   64'(dmem_req_o), 64'd0);
    chk("mis_stall", 64'(mem_stall_o), 64'd1);
    chk("mis_err0",  64'(mem_err_o), 64'd0);
    tick();
    settle();
    chk("mis_err",        64'(mem_err_o), 64'd1);
    chk("mis_done_stall", 64'(mem_stall_o), 64'd0);
    chk("mis_done_req",   64'(dmem_req_o), 64'd0);
    chk("mis_valM",       m_valM_o, 64'h0);
    tick();
    M_opcode_i = 7'h13;
    settle();
    chk("mis_err_clear", 64'(mem_err_o), 64'd0);
    tick();
`else
    // Misaligned SW issues with strobes truncated at the top lane
    run_store("sw_mis", 3'd2, 64'h6, 64'h1122_3344, 64'h1122_3344_1122_3344, 8'hC0);
    chk("sw_mis_err", 64'(mem_err_o), 64'd0);
`endif

    // Reset while BUSY
    set_op(7'h03, 3'd0, 64'h10, 64'h0, 64'h0, 1'b0);
    tick();
    settle();
    chk("abort_busy_req", 64'(dmem_req_o), 64'd1);
    rst_n_i = 1'b0;
    #1;
    chk("abort_req",   64'(dmem_req_o), 64'd0);
    chk("abort_stall", 64'(mem_stall_o), 64'd0);
    chk("abort_addr",  dmem_addr_o, 64'h0);
    chk("abort_we",    64'(dmem_we_o), 64'd0);
    chk("abort_valM",  m_valM_o, 64'h0);
    tick();
    M_opcode_i = 7'h13;
    dmem_ack_i = 1'b1;
    rst_n_i    = 1'b1;
    settle();
    chk("late_ack_req",   64'(dmem_req_o), 64'd0);
    chk("late_ack_stall", 64'(mem_stall_o), 64'd0);
    tick();
    settle();
    chk("late_ack2_stall", 64'(mem_stall_o), 64'd0);
    chk("late_ack2_valM",  m_valM_o, 64'h0);
    dmem_ack_i = 1'b0;
    set_op(7'h03, 3'd0, 64'h10, 64'h0, 64'h7F, 1'b0);
    #1;
    chk("post_abort_idle_stall", 64'(mem_stall_o), 64'd1);
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    settle();
    chk("post_abort_valM", m_valM_o, 64'h7F);
    tick();
    M_opcode_i = 7'h13;
    tick();

    // Non-memory opcode with a stray ack
    set_op(7'h33, 3'd0, 64'h1000, 64'h55, 64'hFFFF, 1'b1);
    settle();
    chk("nonmem_req",   64'(dmem_req_o), 64'd0);
    chk("nonmem_stall", 64'(mem_stall_o), 64'd0);
    chk("nonmem_valM",  m_valM_o, 64'h0);
    tick();
    settle();
    chk("nonmem_next_stall", 64'(mem_stall_o), 64'd0);
    chk("nonmem_next_valM",  m_valM_o, 64'h0);
    dmem_ack_i = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
